float_sqrt_iter: RTL and testbench

- Parametrised IEEE-754 square-root unit for the FPU: EW-bit exponent, FW-bit fraction; default is binary32.
- Iterative restoring digit-recurrence core, one root bit per cycle. No external Newton-Raphson submodule.
- Handles denormal inputs and four rounding modes, and raises invalid/inexact flags.
- Valid/ready handshake on input and output so the pipeline can stall it. Sits beside the FP divider in the execute stage.

---
 rtl/float_sqrt_iter.sv | 225 ++++++++++++++++++++++
 tb/tb_float_sqrt_iter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/float_sqrt_iter.sv
// IEEE-754 square root: restoring digit recurrence producing one root bit per cycle,
// with denormal normalisation, four rounding modes and valid/ready handshakes.
module float_sqrt_iter #(
    parameter int EW = 8,
    parameter int FW = 23,
    parameter int CW = 6,
    localparam int W = 1 + EW + FW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  d,
    input  logic [1:0]    rm,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  s,
    output logic          flag_invalid,
    output logic          flag_inexact,
    output logic          busy,
    output logic [CW-1:0] count
);

    localparam int SW   = FW + 1;        // significand incl. hidden bit
    localparam int RTW  = FW + 2;        // root: integer bit, FW fraction bits, guard bit
    localparam int RADW = 2 * RTW;       // radicand: two bits consumed per root bit
    localparam int RW   = FW + 4;        // partial remainder
    localparam int XW   = EW + 2;        // signed exponent arithmetic
    localparam logic signed [XW-1:0] BIAS_X = XW'((1 << (EW - 1)) - 1);
    localparam logic signed [XW-1:0] ONE_X  = XW'(1);
    localparam logic [W-1:0] QNAN = {1'b0, {EW{1'b1}}, 1'b1, {(FW-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, NORM, ITER, ROUND, DONE} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    d_q, d_d;
    logic [1:0]      rm_q, rm_d;
    logic [RADW-1:0] rad_q, rad_d;
    logic [RW-1:0]   rem_q, rem_d;
    logic [RTW-1:0]  root_q, root_d;
    logic [EW-1:0]   exp_q, exp_d;
    logic [CW-1:0]   count_q, count_d;
    logic            out_valid_q, out_valid_d;
    logic [W-1:0]    s_q, s_d;
    logic            inv_q, inv_d;
    logic            inx_q, inx_d;

    logic                 sign;
    logic [EW-1:0]        e_fld;
    logic [FW-1:0]        f_fld;
    logic                 e_max, e_zero, f_zero;
    logic [SW-1:0]        sig_sub, sig_norm;
    logic [CW-1:0]        lz;
    logic                 lz_found;
    logic signed [XW-1:0] e_unb, e_adj;
    logic                 e_odd;
    logic [RW+2:0]        trial;
    logic                 trial_neg;
    logic                 guard, sticky, inc;
    logic [RTW-1:0]       mant_r;

    assign sign    = d_q[W-1];
    assign e_fld   = d_q[W-2:FW];
    assign f_fld   = d_q[FW-1:0];
    assign e_max   = &e_fld;
    assign e_zero  = ~|e_fld;
    assign f_zero  = ~|f_fld;
    assign sig_sub = {1'b0, f_fld};

    // Leading-zero count over the hidden-bit-extended significand of a denormal
    always_comb begin
        lz       = '0;
        lz_found = 1'b0;
        for (int i = SW - 1; i >= 0; i--) begin
            if (!lz_found && sig_sub[i]) begin
                lz       = CW'(SW - 1 - i);
                lz_found = 1'b1;
            end
        end
    end

    assign sig_norm = e_zero ? (sig_sub << lz) : {1'b1, f_fld};
    assign e_unb    = e_zero ? (ONE_X - BIAS_X - $signed(XW'(lz)))
                             : ($signed({2'b00, e_fld}) - BIAS_X);
    assign e_odd    = e_unb[0];
    assign e_adj    = e_odd ? (e_unb - ONE_X) : e_unb;

    assign trial     = {1'b0, rem_q, rad_q[RADW-1 -: 2]} - {3'b000, root_q, 2'b01};
    assign trial_neg = trial[RW+2];

    assign guard  = root_q[0];
    assign sticky = |rem_q;
    always_comb begin
        case (rm_q)
            2'b00:   inc = guard & (root_q[1] | sticky);
            2'b10:   inc = guard | sticky;
            default: inc = 1'b0;
        endcase
    end
    assign mant_r = {1'b0, root_q[RTW-1:1]} + RTW'(inc);

    always_comb begin
        state_d     = state_q;
        d_d         = d_q;
        rm_d        = rm_q;
        rad_d       = rad_q;
        rem_d       = rem_q;
        root_d      = root_q;
        exp_d       = exp_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        s_d         = s_q;
        inv_d       = inv_q;
        inx_d       = inx_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    d_d     = d;
                    rm_d    = rm;
                    state_d = NORM;
                end
            end
            NORM: begin
                inv_d = 1'b0;
                inx_d = 1'b0;
                if (e_max && !f_zero) begin
                    s_d         = QNAN;
                    inv_d       = ~f_fld[FW-1];
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else if (sign && !(e_zero && f_zero)) begin
                    s_d         = QNAN;
                    inv_d       = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else if ((e_zero && f_zero) || e_max) begin
                    s_d         = d_q;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    // Odd exponent: fold one factor of two into the radicand
                    rad_d   = e_odd ? {sig_norm, 1'b0, {RTW{1'b0}}}
                                    : {1'b0, sig_norm, {RTW{1'b0}}};
                    exp_d   = EW'((e_adj >>> 1) + BIAS_X);
                    rem_d   = '0;
                    root_d  = '0;
                    count_d = CW'(FW + 2);
                    state_d = ITER;
                end
            end
            ITER: begin
                rem_d   = trial_neg ? RW'({rem_q, rad_q[RADW-1 -: 2]}) : RW'(trial);
                root_d  = {root_q[RTW-2:0], ~trial_neg};
                rad_d   = rad_q << 2;
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    state_d = ROUND;
                end
            end
            ROUND: begin
                // A carry out of the significand leaves the fraction zero and bumps the exponent
                s_d         = {1'b0, exp_q + EW'(mant_r[RTW-1]), FW'(mant_r)};
                inx_d       = guard | sticky;
                inv_d       = 1'b0;
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            s_d         = '0;
            inv_d       = 1'b0;
            inx_d       = 1'b0;
            count_d     = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            d_q         <= '0;
            rm_q        <= '0;
            rad_q       <= '0;
            rem_q       <= '0;
            root_q      <= '0;
            exp_q       <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            s_q         <= '0;
            inv_q       <= 1'b0;
            inx_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            d_q         <= d_d;
            rm_q        <= rm_d;
            rad_q       <= rad_d;
            rem_q       <= rem_d;
            root_q      <= root_d;
            exp_q       <= exp_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            s_q         <= s_d;
            inv_q       <= inv_d;
            inx_q       <= inx_d;
        end
    end

    assign in_ready     = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign out_valid    = out_valid_q;
    assign s            = s_q;
    assign flag_invalid = inv_q;
    assign flag_inexact = inx_q;
    assign count        = count_q;

endmodule

// File: tb/tb_float_sqrt_iter.sv
// Bench for float_sqrt_iter (binary32): real-arithmetic reference model, a negedge
// compare process against a queue of expected results, and directed literal vectors.
module tb_float_sqrt_iter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] d = '0;
    logic [1:0]  rm = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] s;
    logic        flag_invalid;
    logic        flag_inexact;
    logic        busy;
    logic [5:0]  count;

    float_sqrt_iter dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .d(d), .rm(rm), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .flag_invalid(flag_invalid), .flag_inexact(flag_inexact),
        .busy(busy), .count(count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int ndone = 0;
    logic [31:0] last_s;
    logic [1:0]  last_f;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp_v);
        end
    endtask

    function automatic real pow2(input int e);
        real r;
        r = 1.0;
        if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
        else        for (int i = 0; i < -e; i++) r = r / 2.0;
        return r;
    endfunction

    // Reference: decode, take the real square root, then round to binary32.
    // lat = clock edges from the acceptance edge to the edge that raises out_valid.
    function automatic void model(input logic [31:0] x, input logic [1:0] m,
                                  output logic [31:0] res, output logic inv,
                                  output logic inx, output int lat);
        int ex, fr, ey, t;
        real v, y, sc, rem;
        logic inc;
        ex = int'(x[30:23]);
        fr = int'(x[22:0]);
        inv = 1'b0;
        inx = 1'b0;
        lat = 1;
        res = 32'h7FC00000;
        if (ex == 255 && fr != 0) begin
            inv = ~x[22];
            return;
        end
        if (ex == 0 && fr == 0) begin
            res = x;
            return;
        end
        if (x[31]) begin
            inv = 1'b1;
            return;
        end
        if (ex == 255) begin
            res = x;
            return;
        end
        lat = 27;
        if (ex == 0) v = fr * pow2(-149);
        else         v = (1.0 + fr * pow2(-23)) * pow2(ex - 127);
        y = $sqrt(v);
        ey = 0;
        while (y >= 2.0) begin y = y / 2.0; ey++; end
        while (y < 1.0)  begin y = y * 2.0; ey--; end
        sc  = (y - 1.0) * 8388608.0;
        t   = int'($floor(sc));
        rem = sc - t;
        case (m)
            2'b00:   inc = (rem > 0.5) || (rem == 0.5 && t[0]);
            2'b10:   inc = (rem > 0.0);
            default: inc = 1'b0;
        endcase
        if (inc) t++;
        if (t == 8388608) begin
            t = 0;
            ey++;
        end
        res = {1'b0, 8'(ey + 127), 23'(t)};
        inx = (rem != 0.0);
    endfunction

    typedef struct {
        logic [31:0] dv;
        logic [1:0]  rmv;
        logic [31:0] s;
        logic        inv;
        logic        inx;
        int          lat;
        int          acc;
    } exp_t;

    exp_t q[$];
    logic seen = 1'b0;

    // Compare process: outputs are checked against the queue head on every valid cycle.
    always @(negedge clk) begin
        exp_t e;
        logic [31:0] ms;
        logic mi, mx;
        int ml;
        if (!rst_n) begin
            chk("reset_outputs", {out_valid, busy, flag_invalid, flag_inexact, count, s}, 64'h0);
            q.delete();
            seen = 1'b0;
        end else begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_out_valid: got s=%08h with no operand pending", s);
                end else begin
                    e = q[0];
                    chk($sformatf("s_%08h_rm%0d", e.dv, e.rmv), s, e.s);
                    chk("flags", {flag_invalid, flag_inexact}, {e.inv, e.inx});
                    chk("in_ready_while_valid", in_ready, 0);
                    if (!seen) begin
                        chk($sformatf("latency_%08h", e.dv), cyc - e.acc, e.lat);
                        seen = 1'b1;
                    end
                    if (out_ready && !flush) begin
                        $display("txn d=%08h rm=%0d s=%08h inv=%0b inx=%0b lat=%0d",
                                 e.dv, e.rmv, s, flag_invalid, flag_inexact, e.lat);
                        last_s = s;
                        last_f = {flag_invalid, flag_inexact};
                        void'(q.pop_front());
                        seen = 1'b0;
                        ndone++;
                    end
                end
            end
            if (flush) begin
                q.delete();
                seen = 1'b0;
            end else if (in_valid && in_ready) begin
                model(d, rm, ms, mi, mx, ml);
                e.dv = d; e.rmv = rm; e.s = ms; e.inv = mi; e.inx = mx; e.lat = ml;
                e.acc = cyc + 1;
                q.push_back(e);
            end
        end
    end

    task automatic do_op(input logic [31:0] dv, input logic [1:0] rmv);
        int n, start;
        n = 0;
        while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
        chk("wait_in_ready", n < 100, 1);
        start = ndone;
        d = dv; rm = rmv; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (ndone == start && n < 100) begin @(posedge clk); #1; n++; end
        chk("wait_result", ndone != start, 1);
    endtask

    task automatic op_lit(input logic [31:0] dv, input logic [1:0] rmv,
                          input logic [31:0] es, input logic [1:0] ef);
        do_op(dv, rmv);
        chk($sformatf("lit_s_%08h_rm%0d", dv, rmv), last_s, es);
        chk($sformatf("lit_f_%08h_rm%0d", dv, rmv), last_f, ef);
    endtask

    // Hand-computed vectors: operand, rm, result, {invalid, inexact}
    localparam int NV = 20;
    logic [31:0] vd [NV] = '{32'h40800000, 32'h40000000, 32'h40000000, 32'h40000000,
                             32'h40000000, 32'hC0800000, 32'h80000000, 32'h7F800000,
                             32'h7F800001, 32'h00000001, 32'h00400000, 32'h41100000,
                             32'h3F800000, 32'hFFC00000, 32'hFF800000, 32'h00000000,
                             32'h3F800001, 32'h3F800001, 32'h7F7FFFFF, 32'h7F7FFFFF};
    logic [1:0]  vr [NV] = '{2'd0, 2'd0, 2'd2, 2'd3, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0,
                             2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd2};
    logic [31:0] vs [NV] = '{32'h40000000, 32'h3FB504F3, 32'h3FB504F4, 32'h3FB504F3,
                             32'h3FB504F3, 32'h7FC00000, 32'h80000000, 32'h7F800000,
                             32'h7FC00000, 32'h1A3504F3, 32'h1FB504F3, 32'h40400000,
                             32'h3F800000, 32'h7FC00000, 32'h7FC00000, 32'h00000000,
                             32'h3F800000, 32'h3F800001, 32'h5F7FFFFF, 32'h5F800000};
    logic [1:0]  vf [NV] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b00, 2'b00,
                             2'b10, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00,
                             2'b01, 2'b01, 2'b01, 2'b01};
    localparam int NM = 6;
    logic [31:0] md [NM] = '{32'h3E99999A, 32'h00800000, 32'h007FFFFF, 32'h42F6E979,
                             32'h0000ABCD, 32'h3F7FFFFF};

    initial begin
        logic [31:0] ms;
        logic mi, mx;
        int ml, n;

        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("idle_in_ready", in_ready, 1);
        chk("idle_busy", busy, 0);

        model(32'h40000000, 2'b00, ms, mi, mx, ml);
        chk("model_sqrt2_rne", {ms, mi, mx}, {32'h3FB504F3, 1'b0, 1'b1});
        model(32'h40000000, 2'b10, ms, mi, mx, ml);
        chk("model_sqrt2_up", ms, 32'h3FB504F4);
        model(32'h00000001, 2'b00, ms, mi, mx, ml);
        chk("model_min_denorm", ms, 32'h1A3504F3);
        model(32'h40800000, 2'b00, ms, mi, mx, ml);
        chk("model_four", {ms, mi, mx, 32'(ml)}, {32'h40000000, 1'b0, 1'b0, 32'd27});
        model(32'h7F800001, 2'b00, ms, mi, mx, ml);
        chk("model_snan", {ms, mi, 32'(ml)}, {32'h7FC00000, 1'b1, 32'd1});

        for (int i = 0; i < NV; i++) op_lit(vd[i], vr[i], vs[i], vf[i]);
        for (int i = 0; i < NM; i++)
            for (int r = 0; r < 4; r++) do_op(md[i], 2'(r));

        // Backpressure: result must hold while the consumer stalls
        out_ready = 1'b0;
        d = 32'h40800000; rm = 2'b00; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
        chk("bp_wait_valid", out_valid, 1);
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            d = 32'h41100000;
            @(posedge clk); #1;
            chk("bp_in_ready", in_ready, 0);
            chk("bp_hold", {out_valid, flag_invalid, flag_inexact, s}, {3'b100, 32'h40000000});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release", {in_ready, out_valid}, 2'b10);

        // Flush in the tenth iteration cycle
        d = 32'h40800000; rm = 2'b00; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("flush_count_load", count, 25);
        repeat (9) begin @(posedge clk); #1; end
        chk("flush_count_iter10", count, 16);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_idle", {in_ready, busy, out_valid, flag_invalid, flag_inexact, count},
            {5'b10000, 6'd0});
        chk("flush_s", s, 0);
        repeat (40) @(posedge clk);
        #1;
        op_lit(32'h40800000, 2'b00, 32'h40000000, 2'b00);
        op_lit(32'h40000000, 2'b00, 32'h3FB504F3, 2'b01);

        // Asynchronous reset in the middle of iteration
        d = 32'h41100000; rm = 2'b00; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) begin @(posedge clk); #1; end
        chk("pre_reset_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("reset_async", {out_valid, busy, flag_invalid, flag_inexact, count, s}, 64'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        op_lit(32'h41100000, 2'b00, 32'h40400000, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion want completion before 500us");
        $fatal(1, "watchdog expired");
    end

endmodule
